fifo_wr_packer: RTL and testbench
=================================

Name: fifo_wr_packer

Overview:
- Write-side producer for the team's async FIFO. Runs in the wr_clk domain and packs a narrow valid/ready byte stream into FIFO-width words.
- Drives the FIFO write port (wr_en/din) and honours its combinational full flag: the FIFO silently drops writes while full, so this block holds each word until the FIFO accepts it.
- Each word carries a last flag and a valid-lane count so the read side can unpack frames.

Parameters:
- IN_WIDTH, 8: bits per input beat (one lane).
- PACK, 4: lanes per FIFO word; must be a power of two ≥2.
- LANE_W, $clog2(PACK): width of the lane-count field.
- FIFO_W, PACK*IN_WIDTH+LANE_W+1: width of fifo_din. The FIFO is instantiated with DATA_WIDTH=FIFO_W.

Ports:
- wr_clk  in  1  write-domain clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready at posedge.
- s_data  in  IN_WIDTH  input lane data.
- s_last  in  1  final beat of frame.
- flush  in  1  single-cycle request to emit a partial word without last.
- fifo_full  in  1  FIFO full flag (combinational from FIFO).
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  FIFO_W  word = {last, lanes-1, data}; lane 0 occupies data[IN_WIDTH-1:0].

Behaviour:
- Reset: acc=0, cnt=0, out_valid=0, fifo_wr_en=0, fifo_din=0. s_ready=1 once out of reset. Reset mid-frame discards partial accumulator and held word.
- Storage: accumulator acc (PACK lanes), lane counter cnt (0..PACK-1), output hold register (out_word, out_valid). fifo_wr_en=out_valid, fifo_din=out_word.
- Drain: a word leaves the hold register at a posedge with out_valid && !fifo_full.
- s_ready = !out_valid || !fifo_full (registered out_valid, combinational fifo_full; no dependence on s_data/s_last).
- Accept, non-completing beat (cnt<PACK-1 and !s_last): acc[cnt] <= s_data; cnt++.
- Accept, completing beat (cnt==PACK-1 or s_last): out_word <= {s_last, cnt, acc with lane cnt = s_data, lanes > cnt zeroed}; out_valid <= 1; acc <= 0; cnt <= 0.
- Hold-register FSM:
  - EMPTY→FULL on a completing accept.
  - FULL→EMPTY on drain with no completing accept.
  - FULL→FULL on drain plus a simultaneous completing accept.
- Latency: completing beat accepted at edge N → fifo_wr_en=1 during cycle N+1 → FIFO write at edge N+1 if !fifo_full.
- Sustained rate: PACK beats per word, zero bubbles while the FIFO is not full.
- Full stall: out_word and fifo_wr_en held stable until !fifo_full. s_ready=0 while stalled.
- Flush:
  - If cnt>0 and no beat is accepted this cycle, and hold register is empty or draining: emit {0, cnt-1, acc} and clear acc/cnt.
  - If the hold register is stalled, flush stays pending in a sticky flag until it can issue.
  - flush with cnt==0 is a no-op.
  - flush in the same cycle as an accepted beat is deferred one cycle; the beat takes priority.
- s_last with cnt==0 produces a single-lane word, lane-count field 0.
- Lane-count field: width LANE_W, value = valid lanes − 1; wraps naturally.

Optional Feature:
- Macro WR_PACKER_STATS_EN.
- Defined: adds outputs stat_words[31:0] (incremented per drained word) and stat_stalls[31:0] (incremented each cycle out_valid && fifo_full). Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pack_pkg holds:
  - LANE_W computation function.
  - Field offset constants: LAST_BIT, CNT_LSB, DATA_LSB.
  - Packing function building a word from acc/lane/last.
  - Hold-FSM state enum (EMPTY, FULL).
- One natural sub-module, fifo_wr_hold: output hold register plus drain/stall logic, reusable by other FIFO producers.

Test Plan:
- Reset, then 4 beats 0x11,0x22,0x33,0x44 with s_last on 0x44, fifo_full=0 → one write, fifo_din={1,2'd3,32'h44332211}, fifo_wr_en high exactly one cycle, one cycle after the last beat.
- 3 beats 0xA1,0xA2,0xA3 with s_last on 0xA3 → fifo_din={1,2'd2,32'h00A3A2A1}.
- 8 back-to-back beats, no last, fifo_full=0 → two writes 4 cycles apart, s_ready constantly 1.
- Complete word while fifo_full=1 for 5 cycles → fifo_din stable, fifo_wr_en=1, s_ready=0 throughout; a single write after full drops. stat_stalls=5 when WR_PACKER_STATS_EN is defined.
- 2 beats 0x01,0x02 then flush → fifo_din={0,2'd1,32'h00000201}.
- Assert rst_n low mid-frame after 2 beats, then release and send 4 beats → only the post-reset word is written, with no stale lanes.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pack_pkg
//   Shared definitions for FIFO write-side packers.
//   - lane_width()  : width of the lane-count field for a given lane count
//   - cnt_lsb()/last_bit() : field offsets inside a packed FIFO word
//   - DATA_LSB / CNT_LSB / LAST_BIT : offsets for the default 4 x 8-bit shape
//   - pack_word()   : assembles {last, lanes-1, data} into a word
//   - hold_state_t  : state of an output hold register (EMPTY / FULL)
// -----------------------------------------------------------------------------
package fifo_pack_pkg;

  // Upper bound on any packed word handled by pack_word(); callers truncate
  // the result to their real FIFO width.
  localparam int PKG_MAX_W = 512;

  typedef logic [PKG_MAX_W-1:0] pkg_word_t;

  // Lane data always sits at the bottom of the word, lane 0 lowest.
  localparam int DATA_LSB = 0;

  // Lane-count field holds (valid lanes - 1); a single lane still needs one bit.
  function automatic int lane_width(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

  function automatic int cnt_lsb(input int in_width, input int pack);
    return DATA_LSB + pack * in_width;
  endfunction

  function automatic int last_bit(input int in_width, input int pack);
    return cnt_lsb(in_width, pack) + lane_width(pack);
  endfunction

  // Offsets for the default configuration (IN_WIDTH=8, PACK=4).
  localparam int CNT_LSB  = cnt_lsb(8, 4);
  localparam int LAST_BIT = last_bit(8, 4);

  // Builds {last, lanes_m1, data}. data must already have unused lanes zeroed
  // and lanes_m1 must already be confined to the lane-count width.
  function automatic pkg_word_t pack_word(input pkg_word_t data,
                                          input pkg_word_t lanes_m1,
                                          input logic      last,
                                          input int        in_width,
                                          input int        pack);
    pkg_word_t w;
    w = data
      | (lanes_m1 << cnt_lsb(in_width, pack))
      | (pkg_word_t'(last) << last_bit(in_width, pack));
    return w;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/fifo_wr_hold.sv
// -----------------------------------------------------------------------------
// fifo_wr_hold
//   Output hold register for a FIFO producer. A loaded word is presented on
//   fifo_din with fifo_wr_en high until the FIFO is not full at a clock edge;
//   a new word may be loaded on the same edge the current one drains.
//   Ports:
//     wr_clk      in   write-domain clock
//     rst_n       in   asynchronous active-low reset
//     load        in   capture load_word this cycle (ignored while stalled)
//     load_word   in   word to capture
//     fifo_full   in   FIFO full flag (combinational)
//     out_valid   out  hold register occupied
//     fifo_wr_en  out  FIFO write enable (registered)
//     fifo_din    out  FIFO write data (registered)
// -----------------------------------------------------------------------------
module fifo_wr_hold
  import fifo_pack_pkg::*;
#(
  parameter int W = 35
) (
  input  logic         wr_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         fifo_full,
  output logic         out_valid,
  output logic         fifo_wr_en,
  output logic [W-1:0] fifo_din
);

  hold_state_t  state_reg;
  logic         wr_en_reg;
  logic [W-1:0] word_reg;

  assign out_valid  = (state_reg == FULL);
  assign fifo_wr_en = wr_en_reg;
  assign fifo_din   = word_reg;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      wr_en_reg <= 1'b0;
      word_reg  <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (load) begin
            state_reg <= FULL;
            wr_en_reg <= 1'b1;
            word_reg  <= load_word;
          end
        end
        FULL: begin
          // While the FIFO is full the word and write enable stay frozen.
          if (!fifo_full) begin
            if (load) begin
              word_reg <= load_word;
            end else begin
              state_reg <= EMPTY;
              wr_en_reg <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// fifo_wr_packer
//   Packs a valid/ready stream of IN_WIDTH-bit beats into FIFO words of PACK
//   lanes: fifo_din = {last, lanes-1, data}, lane 0 in the low bits. Words are
//   held until the FIFO accepts them. A flush pulse emits a partial word
//   (last=0) without waiting for more beats.
//   Ports:
//     wr_clk       in   write-domain clock
//     rst_n        in   asynchronous active-low reset
//     s_valid      in   input beat valid
//     s_ready      out  input beat may be accepted
//     s_data       in   input lane data
//     s_last       in   final beat of frame
//     flush        in   request to emit the current partial word
//     fifo_full    in   FIFO full flag (combinational)
//     fifo_wr_en   out  FIFO write enable
//     fifo_din     out  FIFO write word
//     stat_words   out  drained-word counter     (WR_PACKER_STATS_EN only)
//     stat_stalls  out  stalled-cycle counter    (WR_PACKER_STATS_EN only)
//   Build option: define WR_PACKER_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module fifo_wr_packer
  import fifo_pack_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int PACK     = 4,
  parameter int LANE_W   = lane_width(PACK),
  parameter int FIFO_W   = PACK * IN_WIDTH + LANE_W + 1
) (
  input  logic                wr_clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_data,
  input  logic                s_last,
  input  logic                flush,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [FIFO_W-1:0]   fifo_din
`ifdef WR_PACKER_STATS_EN
  ,
  output logic [31:0]         stat_words,
  output logic [31:0]         stat_stalls
`endif
);

  logic [PACK-1:0][IN_WIDTH-1:0] acc_reg;
  logic [PACK-1:0][IN_WIDTH-1:0] acc_next;
  logic [PACK-1:0][IN_WIDTH-1:0] load_data;
  logic [LANE_W-1:0]             cnt_reg;
  logic [LANE_W-1:0]             cnt_next;
  logic                          flush_pend_reg;
  logic                          flush_pend_next;

  logic              out_valid;
  logic              accept;
  logic              complete;
  logic              flush_req;
  logic              flush_fire;
  logic              cnt_nz;
  logic              load;
  logic              load_last;
  logic [LANE_W-1:0] load_lanes_m1;
  logic [FIFO_W-1:0] load_word;
  logic [PACK-1:0]   lane_hit;

  // Ready only depends on the hold register and the FIFO, never on s_data.
  assign s_ready = !out_valid || !fifo_full;
  assign accept  = s_valid && s_ready;
  assign cnt_nz  = (cnt_reg != '0);

  assign complete = accept && ((cnt_reg == LANE_W'(PACK - 1)) || s_last);

  // A flush that coincides with an accepted beat waits a cycle so the beat
  // lands in the partial word first; the sticky flag also carries a flush
  // across a stalled hold register.
  assign flush_req       = flush || flush_pend_reg;
  assign flush_fire      = flush_req && !accept && cnt_nz && s_ready;
  assign flush_pend_next = flush_req && !flush_fire && (accept || cnt_nz);

  assign load          = complete || flush_fire;
  assign load_last     = complete && s_last;
  assign load_lanes_m1 = complete ? cnt_reg : (cnt_reg - LANE_W'(1));
  assign cnt_next      = load ? '0 : (accept ? (cnt_reg + LANE_W'(1)) : cnt_reg);

  // Per-lane word assembly. The same mux serves both completion (the current
  // beat fills lane cnt) and flush (no beat, lanes below cnt only); lanes
  // above the fill point are forced to zero so no stale data leaks out.
  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      assign lane_hit[gi]  = (cnt_reg == LANE_W'(gi));
      assign load_data[gi] = (accept && lane_hit[gi]) ? s_data
                           : (cnt_reg > LANE_W'(gi))  ? acc_reg[gi]
                           : '0;
      assign acc_next[gi]  = load                     ? '0
                           : (accept && lane_hit[gi]) ? s_data
                           : acc_reg[gi];
    end
  endgenerate

  assign load_word = FIFO_W'(pack_word(pkg_word_t'(load_data),
                                       pkg_word_t'(load_lanes_m1),
                                       load_last, IN_WIDTH, PACK));

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  fifo_wr_hold #(
    .W (FIFO_W)
  ) u_hold (
    .wr_clk     (wr_clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_word  (load_word),
    .fifo_full  (fifo_full),
    .out_valid  (out_valid),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din)
  );

`ifdef WR_PACKER_STATS_EN
  logic [31:0] stat_words_reg;
  logic [31:0] stat_stalls_reg;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_reg  <= '0;
      stat_stalls_reg <= '0;
    end else begin
      if (out_valid && !fifo_full) stat_words_reg  <= stat_words_reg + 32'd1;
      if (out_valid &&  fifo_full) stat_stalls_reg <= stat_stalls_reg + 32'd1;
    end
  end

  assign stat_words  = stat_words_reg;
  assign stat_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_packer
//   Directed bench for fifo_wr_packer (IN_WIDTH=8, PACK=4, FIFO_W=35).
//   Each FIFO write is logged on its own line; each scenario task checks
//   outputs against hand-computed words.
// -----------------------------------------------------------------------------
module tb_fifo_wr_packer;

  localparam int IN_WIDTH = 8;
  localparam int PACK     = 4;
  localparam int FIFO_W   = 35;

  logic                wr_clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [IN_WIDTH-1:0] s_data = '0;
  logic                s_last = 1'b0;
  logic                flush = 1'b0;
  logic                fifo_full = 1'b0;
  logic                fifo_wr_en;
  logic [FIFO_W-1:0]   fifo_din;
`ifdef WR_PACKER_STATS_EN
  logic [31:0]         stat_words;
  logic [31:0]         stat_stalls;
`endif

  fifo_wr_packer #(
    .IN_WIDTH (IN_WIDTH),
    .PACK     (PACK)
  ) dut (
    .wr_clk      (wr_clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .flush       (flush),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din)
`ifdef WR_PACKER_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cycle_cnt = 0;

  logic [FIFO_W-1:0] wr_q[$];
  int                wr_cyc_q[$];

  always @(posedge wr_clk) cycle_cnt++;

  // Inputs only change just after a rising edge, so a write seen here at the
  // falling edge is exactly the write the FIFO takes at the next rising edge.
  always @(negedge wr_clk) begin
    if (rst_n && fifo_wr_en && !fifo_full) begin
      wr_q.push_back(fifo_din);
      wr_cyc_q.push_back(cycle_cnt);
      $display("[%0t] fifo write din=%h (last=%b lanes_m1=%0d data=%h)",
               $time, fifo_din, fifo_din[34], fifo_din[33:32], fifo_din[31:0]);
    end
  end

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en);
    else pass_cnt++;
    total_cnt++;
    if (fifo_din !== 35'h0) $display("FAIL reset_din got=%h exp=0", fifo_din);
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (s_ready !== 1'b1) $display("FAIL reset_s_ready got=%b exp=1", s_ready);
    else pass_cnt++;
    step();
  endtask

  task automatic test_full_word();
    wr_q.delete();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    total_cnt++;
    if (fifo_wr_en !== 1'b0) $display("FAIL word_early_wr_en got=%b exp=0", fifo_wr_en);
    else pass_cnt++;
    send(8'h44, 1'b1);
    total_cnt++;
    if (fifo_wr_en !== 1'b1) $display("FAIL word_wr_en got=%b exp=1", fifo_wr_en);
    else pass_cnt++;
    total_cnt++;
    if (fifo_din !== 35'h7_44332211) $display("FAIL word_din got=%h exp=%h", fifo_din, 35'h7_44332211);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fifo_wr_en !== 1'b0) $display("FAIL word_wr_en_drop got=%b exp=0", fifo_wr_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wr_q.size() !== 1) $display("FAIL word_count got=%0d exp=1", wr_q.size());
    else pass_cnt++;
  endtask

  task automatic test_partial_last();
    wr_q.delete();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    total_cnt++;
    if (fifo_din !== 35'h6_00A3A2A1) $display("FAIL partial_din got=%h exp=%h", fifo_din, 35'h6_00A3A2A1);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (wr_q.size() !== 1) $display("FAIL partial_count got=%0d exp=1", wr_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ready_bad;
    ready_bad = 0;
    wr_q.delete();
    wr_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'h10 + 8'(i);
      s_last  = 1'b0;
      #1;
      if (s_ready !== 1'b1) ready_bad++;
      @(posedge wr_clk);
      #1;
    end
    s_valid = 1'b0;
    step();
    step();
    total_cnt++;
    if (ready_bad !== 0) $display("FAIL b2b_ready_low got=%0d cycles exp=0", ready_bad);
    else pass_cnt++;
    total_cnt++;
    if (wr_q.size() !== 2) begin
      $display("FAIL b2b_count got=%0d exp=2", wr_q.size());
    end else begin
      pass_cnt++;
      total_cnt++;
      if (wr_q[0] !== 35'h3_13121110) $display("FAIL b2b_word0 got=%h exp=%h", wr_q[0], 35'h3_13121110);
      else pass_cnt++;
      total_cnt++;
      if (wr_q[1] !== 35'h3_17161514) $display("FAIL b2b_word1 got=%h exp=%h", wr_q[1], 35'h3_17161514);
      else pass_cnt++;
      total_cnt++;
      if (wr_cyc_q[1] - wr_cyc_q[0] !== 4)
        $display("FAIL b2b_spacing got=%0d exp=4", wr_cyc_q[1] - wr_cyc_q[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_full_stall();
    int stall_bad;
`ifdef WR_PACKER_STATS_EN
    logic [31:0] stalls_base;
    logic [31:0] words_base;
    stalls_base = stat_stalls;
    words_base  = stat_words;
`endif
    stall_bad = 0;
    wr_q.delete();
    fifo_full = 1'b1;
    #1;
    total_cnt++;
    if (s_ready !== 1'b1) $display("FAIL stall_ready_empty got=%b exp=1", s_ready);
    else pass_cnt++;
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    send(8'h53, 1'b0);
    send(8'h54, 1'b1);
    // Offer a beat throughout the stall; it must not be taken.
    s_valid = 1'b1;
    s_data  = 8'hEE;
    s_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (fifo_wr_en !== 1'b1 || fifo_din !== 35'h7_54535251 || s_ready !== 1'b0) stall_bad++;
      step();
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    fifo_full = 1'b0;
    step();
    total_cnt++;
    if (stall_bad !== 0) $display("FAIL stall_hold got=%0d bad cycles exp=0", stall_bad);
    else pass_cnt++;
    total_cnt++;
    if (fifo_wr_en !== 1'b0) $display("FAIL stall_wr_en_after got=%b exp=0", fifo_wr_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wr_q.size() !== 1) begin
      $display("FAIL stall_count got=%0d exp=1", wr_q.size());
    end else begin
      pass_cnt++;
      total_cnt++;
      if (wr_q[0] !== 35'h7_54535251) $display("FAIL stall_word got=%h exp=%h", wr_q[0], 35'h7_54535251);
      else pass_cnt++;
    end
`ifdef WR_PACKER_STATS_EN
    total_cnt++;
    if (stat_stalls - stalls_base !== 32'd5)
      $display("FAIL stat_stalls got=%0d exp=5", stat_stalls - stalls_base);
    else pass_cnt++;
    total_cnt++;
    if (stat_words - words_base !== 32'd1)
      $display("FAIL stat_words got=%0d exp=1", stat_words - words_base);
    else pass_cnt++;
`endif
  endtask

  task automatic test_flush();
    wr_q.delete();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    total_cnt++;
    if (fifo_wr_en !== 1'b1) $display("FAIL flush_wr_en got=%b exp=1", fifo_wr_en);
    else pass_cnt++;
    total_cnt++;
    if (fifo_din !== 35'h1_00000201) $display("FAIL flush_din got=%h exp=%h", fifo_din, 35'h1_00000201);
    else pass_cnt++;
    step();
    // Flush with nothing accumulated must not produce a word.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    total_cnt++;
    if (wr_q.size() !== 1) $display("FAIL flush_noop_count got=%0d exp=1", wr_q.size());
    else pass_cnt++;
  endtask

  task automatic test_flush_deferred();
    wr_q.delete();
    send(8'h05, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h06;
    flush   = 1'b1;
    step();
    s_valid = 1'b0;
    flush   = 1'b0;
    total_cnt++;
    if (fifo_wr_en !== 1'b0) $display("FAIL defer_early_wr_en got=%b exp=0", fifo_wr_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fifo_din !== 35'h1_00000605 || fifo_wr_en !== 1'b1)
      $display("FAIL defer_din got=%h/%b exp=%h/1", fifo_din, fifo_wr_en, 35'h1_00000605);
    else pass_cnt++;
    step();
    total_cnt++;
    if (wr_q.size() !== 1) $display("FAIL defer_count got=%0d exp=1", wr_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    wr_q.delete();
    // Held word under a full FIFO, then an asynchronous reset mid-cycle.
    fifo_full = 1'b1;
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send(8'hE4, 1'b1);
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (fifo_wr_en !== 1'b0 || fifo_din !== 35'h0)
      $display("FAIL async_reset got=%b/%h exp=0/0", fifo_wr_en, fifo_din);
    else pass_cnt++;
    step();
    rst_n     = 1'b1;
    fifo_full = 1'b0;
    step();
    // Partial frame wiped by reset.
    send(8'h99, 1'b0);
    send(8'h98, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    step();
    step();
    total_cnt++;
    if (wr_q.size() !== 1) begin
      $display("FAIL rst_mid_count got=%0d exp=1", wr_q.size());
    end else begin
      pass_cnt++;
      total_cnt++;
      if (wr_q[0] !== 35'h3_C4C3C2C1) $display("FAIL rst_mid_word got=%h exp=%h", wr_q[0], 35'h3_C4C3C2C1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_last();
    test_back_to_back();
    test_full_stall();
    test_flush();
    test_flush_deferred();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
